sync_demod_accum: RTL and testbench

Receive-side counterpart of the excitation hold-zero path. Takes 14-bit offset-binary ADC samples from the measurement channel and converts them to two's complement. Using the excitation `Sync` (sign) bit as reference, it performs square-wave phase-sensitive demodulation and accumulates over an integer number of excitation periods. The result is a signed magnitude with a valid pulse for the downstream image-reconstruction interface.

---
 rtl/ect_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 26 ++
 rtl/sync_demod_accum.sv | 191 +++++++++++++++++++
 tb/tb_sync_demod_accum.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ect_pkg.sv
// Shared definitions for the excitation/measurement (ECT) channel:
// sample format, measurement FSM states and offset-binary conversion.
package ect_pkg;

    localparam int unsigned DATA_W = 14;
    localparam logic [DATA_W-1:0] MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } demodState_t;

    // Offset binary to two's complement: flipping the MSB is an XOR with mid-scale.
    function automatic logic signed [DATA_W-1:0] ob_to_tc(input logic [DATA_W-1:0] ob);
        return signed'(ob ^ MIDSCALE);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Qualified Sync history and registered period-boundary strobe (Sync 1->0
// between consecutive qualified samples).
module sync_edge_det (
    input  logic Clk,
    input  logic Rst_n,
    input  logic AdcValid,
    input  logic Sync,
    output logic Boundary
);

    logic syncHist;

    // History only advances on qualified samples, so gaps never form an edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            syncHist <= 1'b0;
            Boundary <= 1'b0;
        end else begin
            Boundary <= AdcValid & syncHist & ~Sync;
            if (AdcValid) begin
                syncHist <= Sync;
            end
        end
    end

endmodule

// File: rtl/sync_demod_accum.sv
// Square-wave phase-sensitive demodulator: converts ADC samples, multiplies by
// the excitation sign and integrates over PERIODS excitation periods.
module sync_demod_accum #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned PERIODS = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [DATA_W-1:0]       AdcIn,
    input  logic                    AdcValid,
    input  logic                    Sync,
    input  logic                    Start,
    output logic                    Busy,
    output logic signed [ACC_W-1:0] DemodOut,
    output logic                    DemodValid,
    output logic                    Err
);
    import ect_pkg::*;

    localparam int unsigned TERM_W = DATA_W + 1;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    // Stage 1: converted sample, sign and boundary flag
    logic                     s1Valid;
    logic                     s1Sign;
    logic                     s1Boundary;
    logic signed [DATA_W-1:0] s1Sample;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1Valid  <= 1'b0;
            s1Sign   <= 1'b0;
            s1Sample <= '0;
        end else begin
            s1Valid <= AdcValid;
            if (AdcValid) begin
                s1Sign   <= Sync;
                s1Sample <= ob_to_tc(AdcIn);
            end
        end
    end

    sync_edge_det uEdgeDet (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .AdcValid (AdcValid),
        .Sync     (Sync),
        .Boundary (s1Boundary)
    );

    // Stage 2 state
    demodState_t              state;
    demodState_t              stateNext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  accNext;
    logic [CNT_W-1:0]         periodCnt;
    logic [CNT_W-1:0]         periodNext;
    logic [TO_W-1:0]          toCnt;
    logic [TO_W-1:0]          toNext;
    logic                     busyNext;
    logic signed [ACC_W-1:0]  demodOutNext;
    logic                     demodValidNext;
    logic                     errNext;

    // Signed, saturating accumulate of the demodulated term; -(-2^(DATA_W-1)) fits in TERM_W.
    logic signed [TERM_W-1:0] termExt;
    logic signed [TERM_W-1:0] term;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ACC_W-1:0]  accSat;
    logic                     satHit;

    always_comb begin
        termExt = TERM_W'(s1Sample);
        term    = s1Sign ? -termExt : termExt;
        sum     = SUM_W'(acc) + SUM_W'(term);
        satHit  = sum[ACC_W] ^ sum[ACC_W-1];
        if (satHit) begin
            accSat = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            accSat = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            periodCnt  <= '0;
            toCnt      <= '0;
            Busy       <= 1'b0;
            DemodOut   <= '0;
            DemodValid <= 1'b0;
            Err        <= 1'b0;
        end else begin
            state      <= stateNext;
            acc        <= accNext;
            periodCnt  <= periodNext;
            toCnt      <= toNext;
            Busy       <= busyNext;
            DemodOut   <= demodOutNext;
            DemodValid <= demodValidNext;
            Err        <= errNext;
        end
    end

    logic             boundaryHit;
    logic [TO_W-1:0]  toInc;
    logic [CNT_W-1:0] periodInc;

    // Next-state and next-output logic; a boundary always pre-empts the timeout.
    always_comb begin
        stateNext      = state;
        accNext        = acc;
        periodNext     = periodCnt;
        toNext         = toCnt;
        busyNext       = Busy;
        demodOutNext   = DemodOut;
        demodValidNext = 1'b0;
        errNext        = Err;
        boundaryHit    = s1Valid & s1Boundary;
        toInc          = toCnt + TO_W'(1);
        periodInc      = periodCnt + CNT_W'(1);

        case (state)
            IDLE: begin
                if (Start) begin
                    stateNext  = ARM;
                    accNext    = '0;
                    periodNext = '0;
                    toNext     = '0;
                    errNext    = 1'b0;
                    busyNext   = 1'b1;
                end
            end
            ARM: begin
                if (boundaryHit) begin
                    stateNext  = ACCUM;
                    accNext    = accSat;
                    errNext    = Err | satHit;
                    periodNext = '0;
                    toNext     = '0;
                end else if (toInc == TO_W'(TIMEOUT)) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                    errNext   = 1'b1;
                    toNext    = '0;
                end else begin
                    toNext = toInc;
                end
            end
            ACCUM: begin
                if (boundaryHit) begin
                    toNext = '0;
                    if (periodInc == CNT_W'(PERIODS)) begin
                        stateNext = DONE;
                    end else begin
                        periodNext = periodInc;
                        accNext    = accSat;
                        errNext    = Err | satHit;
                    end
                end else if (toInc == TO_W'(TIMEOUT)) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                    errNext   = 1'b1;
                    toNext    = '0;
                end else begin
                    toNext = toInc;
                    if (s1Valid) begin
                        accNext = accSat;
                        errNext = Err | satHit;
                    end
                end
            end
            DONE: begin
                stateNext      = IDLE;
                demodOutNext   = acc;
                demodValidNext = 1'b1;
                busyNext       = 1'b0;
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_demod_accum.sv
// Directed bench: two instances (32-bit/2 periods and 16-bit/4 periods) share
// the ADC stream; each has its own Start.
module tb_sync_demod_accum;

    logic               clk = 1'b0;
    logic               rstN;
    logic [13:0]        adcIn;
    logic               adcValid;
    logic               sync;
    logic               start0;
    logic               start1;
    logic               busy0, dv0, err0;
    logic signed [31:0] out0;
    logic               busy1, dv1, err1;
    logic signed [15:0] out1;

    int passed = 0;
    int total  = 0;
    int dvCnt0 = 0;
    int dvCnt1 = 0;

    always #5 clk = ~clk;

    sync_demod_accum #(.DATA_W(14), .ACC_W(32), .PERIODS(2), .TIMEOUT(100)) u0 (
        .Clk(clk), .Rst_n(rstN), .AdcIn(adcIn), .AdcValid(adcValid), .Sync(sync),
        .Start(start0), .Busy(busy0), .DemodOut(out0), .DemodValid(dv0), .Err(err0)
    );

    sync_demod_accum #(.DATA_W(14), .ACC_W(16), .PERIODS(4), .TIMEOUT(100)) u1 (
        .Clk(clk), .Rst_n(rstN), .AdcIn(adcIn), .AdcValid(adcValid), .Sync(sync),
        .Start(start1), .Busy(busy1), .DemodOut(out1), .DemodValid(dv1), .Err(err1)
    );

    always @(posedge clk) begin
        if (dv0) dvCnt0 <= dvCnt0 + 1;
        if (dv1) dvCnt1 <= dvCnt1 + 1;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic [13:0] a, input logic s, input logic v);
        @(negedge clk);
        adcIn = a; sync = s; adcValid = v; start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic idle();
        drive(14'h2000, 1'b0, 1'b0);
    endtask

    // One qualified sample, optionally followed by an unqualified cycle with inverted Sync.
    task automatic sample(input logic [13:0] a, input logic s, input bit gaps);
        drive(a, s, 1'b1);
        if (gaps) drive(a ^ 14'h0ABC, ~s, 1'b0);
    endtask

    task automatic startInst(input int inst);
        @(negedge clk);
        adcValid = 1'b0;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        idle();
    endtask

    // Periods of 4 samples Sync=0 (hi) + 4 samples Sync=1 (lo), closed by a boundary sample.
    task automatic runWave(input int periods, input logic [13:0] hi, input logic [13:0] lo,
                           input bit gaps, input bit midStart);
        sample(lo, 1'b1, gaps);
        sample(lo, 1'b1, gaps);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 4; i++) begin
                sample(hi, 1'b0, gaps);
                if (midStart && p == 1 && i == 1) start0 = 1'b1;
            end
            for (int i = 0; i < 4; i++) sample(lo, 1'b1, gaps);
        end
        sample(hi, 1'b0, 1'b0);
    endtask

    // Result must appear exactly 2 clocks after the final boundary sample.
    task automatic checkDone(input int inst, input string tag, input longint expOut, input logic expErr);
        int dvBefore;
        dvBefore = (inst == 0) ? dvCnt0 : dvCnt1;
        idle();
        check({tag, "_dv_early1"}, (inst == 0) ? dv0 : dv1, 0);
        idle();
        check({tag, "_dv_early2"}, (inst == 0) ? dv0 : dv1, 0);
        idle();
        check({tag, "_dv"}, (inst == 0) ? dv0 : dv1, 1);
        check({tag, "_busy_fall"}, (inst == 0) ? busy0 : busy1, 0);
        check({tag, "_out"}, (inst == 0) ? longint'(out0) : longint'(out1), expOut);
        check({tag, "_err"}, (inst == 0) ? err0 : err1, expErr);
        idle();
        idle();
        check({tag, "_dv_count"}, ((inst == 0) ? dvCnt0 : dvCnt1) - dvBefore, 1);
    endtask

    initial begin
        int n;
        bit seen;
        rstN = 1'b0; adcIn = 14'h2000; adcValid = 1'b0; sync = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        idle(); idle();
        check("rst_busy0", busy0, 0);
        check("rst_dv0", dv0, 0);
        check("rst_err0", err0, 0);
        check("rst_out0", out0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_out1", out1, 0);
        rstN = 1'b1;
        idle();

        // Basic square-wave demodulation: 2 periods x 8 samples x 4096
        startInst(0);
        check("t1_busy_rise", busy0, 1);
        check("t1_err_clear", err0, 0);
        runWave(2, 14'h3000, 14'h1000, 1'b0, 1'b0);
        checkDone(0, "t1", 65536, 1'b0);

        // DC offset cancels over 4 whole periods
        startInst(1);
        runWave(4, 14'h2800, 14'h2800, 1'b0, 1'b0);
        checkDone(1, "dc", 0, 1'b0);

        // Timeout: Sync stuck low, no boundary ever forms
        startInst(0);
        n = 0;
        seen = 1'b0;
        for (int i = 2; i <= 250 && !seen; i++) begin
            drive(14'h2000, 1'b0, 1'b1);
            if (!busy0) begin n = i; seen = 1'b1; end
        end
        check("to_busy_fall_cycle", n, 101);
        check("to_err", err0, 1);
        check("to_out_held", out0, 65536);
        idle();
        check("to_no_dv", dvCnt0, 1);

        // Saturation on the 16-bit instance: 8 x 8191 clamps to 32767
        startInst(1);
        check("sat_err_clear", err1, 0);
        sample(14'h2000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) sample(14'h3FFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sample(14'h2000, 1'b1, 1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) sample(14'h2000, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) sample(14'h2000, 1'b1, 1'b0);
        end
        sample(14'h2000, 1'b0, 1'b0);
        checkDone(1, "sat", 32767, 1'b1);

        // 50% valid gaps plus an ignored Start in ACCUM: same result as t1
        startInst(0);
        runWave(2, 14'h3000, 14'h1000, 1'b1, 1'b1);
        checkDone(0, "gap", 65536, 1'b0);

        // Reset mid-ACCUM, then a clean run
        startInst(0);
        sample(14'h1000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) sample(14'h3000, 1'b0, 1'b0);
        @(negedge clk);
        rstN = 1'b0;
        idle();
        check("mrst_busy", busy0, 0);
        check("mrst_out", out0, 0);
        check("mrst_dv", dv0, 0);
        check("mrst_err", err0, 0);
        idle();
        rstN = 1'b1;
        idle();
        startInst(0);
        runWave(2, 14'h3000, 14'h1000, 1'b0, 1'b0);
        checkDone(0, "post_rst", 65536, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
